// File: rtl/asu_ddr5_pkg.sv
// Shared types and constants for the DDR5 write/read data-path CRC blocks.
package asu_ddr5_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_CRC_LO = 2'd2,
        ST_CRC_HI = 2'd3
    } wr_crc_state_e;

    localparam int CRC_WIDTH = 8;
    localparam logic [CRC_WIDTH-1:0] CRC8_POLY_DEFAULT = 8'h07;

    localparam int BL16_BEATS = 16;
    localparam int BL18_BEATS = 18;

endpackage

// File: rtl/asu_ddr5_crc8_step.sv
// One-beat CRC-8 update: folds pDQ_WIDTH bits into the CRC, DQ0 first, MSB-first LFSR.
module asu_ddr5_crc8_step
    import asu_ddr5_pkg::*;
#(
    parameter int                   pDQ_WIDTH = 4,
    parameter logic [CRC_WIDTH-1:0] pCRC_POLY = CRC8_POLY_DEFAULT
) (
    input  logic [CRC_WIDTH-1:0] crc_in,
    input  logic [pDQ_WIDTH-1:0] data,
    output logic [CRC_WIDTH-1:0] crc_out
);

    logic [CRC_WIDTH-1:0] crc_tmp;
    logic                 fb;

    // Unrolled serial LFSR; the loop variable is the bit position within the beat.
    always_comb begin
        crc_tmp = crc_in;
        fb      = 1'b0;
        for (int i = 0; i < pDQ_WIDTH; i++) begin
            fb      = crc_tmp[CRC_WIDTH-1] ^ data[i];
            crc_tmp = {crc_tmp[CRC_WIDTH-2:0], 1'b0} ^ (fb ? pCRC_POLY : '0);
        end
        crc_out = crc_tmp;
    end

endmodule

// File: rtl/asu_ddr5_write_crc_gen.sv
// Frames DDR5 x4 write bursts: passes BL16 data through with one cycle of latency and,
// when phy_CRC_mode is set, appends two CRC-8 beats to make BL18.
module asu_ddr5_write_crc_gen
    import asu_ddr5_pkg::*;
#(
    parameter int                   pDQ_WIDTH  = 4,
    parameter int                   pBURST_LEN = BL16_BEATS,
    parameter logic [CRC_WIDTH-1:0] pCRC_POLY  = CRC8_POLY_DEFAULT,
    parameter logic [CRC_WIDTH-1:0] pCRC_INIT  = 8'h00
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 crc_mode_i,
    input  logic                 wr_valid_i,
    input  logic [pDQ_WIDTH-1:0] wr_data_i,
    output logic                 wr_ready_o,
    output logic                 dq_valid_o,
    output logic [pDQ_WIDTH-1:0] dq_data_o,
    output logic                 dq_last_o,
    output logic [CRC_WIDTH-1:0] crc_o
);

    localparam int CNT_W = (pBURST_LEN > 1) ? $clog2(pBURST_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(pBURST_LEN - 1);

    wr_crc_state_e        state_reg, state_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic [CRC_WIDTH-1:0] crc_reg, crc_next;
    logic [CRC_WIDTH-1:0] crc_out_reg, crc_out_next;
    logic                 mode_reg, mode_next;
    logic                 ready_reg, ready_next;
    logic                 dq_valid_reg, dq_valid_next;
    logic                 dq_last_reg, dq_last_next;
    logic [pDQ_WIDTH-1:0] dq_data_reg, dq_data_next;

    logic                 accept;
    logic [CRC_WIDTH-1:0] crc_step_in;
    logic [CRC_WIDTH-1:0] crc_step_out;

    assign accept = wr_valid_i & ready_reg;

    // Beat 0 is folded into a freshly initialised CRC, so no residue survives between bursts.
    assign crc_step_in = (state_reg == ST_IDLE) ? pCRC_INIT : crc_reg;

    asu_ddr5_crc8_step #(
        .pDQ_WIDTH (pDQ_WIDTH),
        .pCRC_POLY (pCRC_POLY)
    ) u_crc_step (
        .crc_in  (crc_step_in),
        .data    (wr_data_i),
        .crc_out (crc_step_out)
    );

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        crc_next      = crc_reg;
        crc_out_next  = crc_out_reg;
        mode_next     = mode_reg;
        ready_next    = ready_reg;
        dq_valid_next = 1'b0;
        dq_last_next  = 1'b0;
        dq_data_next  = dq_data_reg;

        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    mode_next     = crc_mode_i;
                    cnt_next      = CNT_W'(1);
                    crc_next      = crc_step_out;
                    dq_valid_next = 1'b1;
                    dq_data_next  = wr_data_i;
                    state_next    = ST_DATA;
                end
            end

            ST_DATA: begin
                if (accept) begin
                    crc_next      = crc_step_out;
                    dq_valid_next = 1'b1;
                    dq_data_next  = wr_data_i;
                    if (cnt_reg == LAST_BEAT) begin
                        cnt_next = '0;
                        if (mode_reg) begin
                            ready_next = 1'b0;
                            state_next = ST_CRC_LO;
                        end else begin
                            crc_out_next = crc_step_out;
                            dq_last_next = 1'b1;
                            state_next   = ST_IDLE;
                        end
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
            end

            ST_CRC_LO: begin
                dq_valid_next = 1'b1;
                dq_data_next  = crc_reg[pDQ_WIDTH-1:0];
                state_next    = ST_CRC_HI;
            end

            ST_CRC_HI: begin
                // Ready is raised here so the next burst can be accepted right after this beat.
                dq_valid_next = 1'b1;
                dq_data_next  = crc_reg[pDQ_WIDTH +: pDQ_WIDTH];
                dq_last_next  = 1'b1;
                crc_out_next  = crc_reg;
                ready_next    = 1'b1;
                state_next    = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            crc_reg      <= pCRC_INIT;
            crc_out_reg  <= '0;
            mode_reg     <= 1'b0;
            ready_reg    <= 1'b1;
            dq_valid_reg <= 1'b0;
            dq_last_reg  <= 1'b0;
            dq_data_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            crc_reg      <= crc_next;
            crc_out_reg  <= crc_out_next;
            mode_reg     <= mode_next;
            ready_reg    <= ready_next;
            dq_valid_reg <= dq_valid_next;
            dq_last_reg  <= dq_last_next;
            dq_data_reg  <= dq_data_next;
        end
    end

    assign wr_ready_o = ready_reg;
    assign dq_valid_o = dq_valid_reg;
    assign dq_data_o  = dq_data_reg;
    assign dq_last_o  = dq_last_reg;
    assign crc_o      = crc_out_reg;

endmodule

// File: tb/tb_asu_ddr5_write_crc_gen.sv
// Directed bench for the DDR5 write CRC framer: vector table plus gap, mode-toggle and reset sequences.
module tb_asu_ddr5_write_crc_gen;

    logic       clk_i      = 1'b0;
    logic       rst_i      = 1'b1;
    logic       crc_mode_i = 1'b0;
    logic       wr_valid_i = 1'b0;
    logic [3:0] wr_data_i  = 4'h0;
    logic       wr_ready_o;
    logic       dq_valid_o;
    logic [3:0] dq_data_o;
    logic       dq_last_o;
    logic [7:0] crc_o;

    int tests = 0;
    int fails = 0;

    always #5 clk_i = ~clk_i;

    asu_ddr5_write_crc_gen dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .crc_mode_i (crc_mode_i),
        .wr_valid_i (wr_valid_i),
        .wr_data_i  (wr_data_i),
        .wr_ready_o (wr_ready_o),
        .dq_valid_o (dq_valid_o),
        .dq_data_o  (dq_data_o),
        .dq_last_o  (dq_last_o),
        .crc_o      (crc_o)
    );

    // Output monitor, sampled on the falling edge.
    logic [3:0] mon_data[$];
    logic       mon_last[$];
    int         mon_cyc[$];
    int         cyc       = 0;
    int         ready_low = 0;

    initial begin
        forever begin
            @(negedge clk_i);
            cyc++;
            if (!wr_ready_o) ready_low++;
            if (dq_valid_o) begin
                mon_data.push_back(dq_data_o);
                mon_last.push_back(dq_last_o);
                mon_cyc.push_back(cyc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required completion within 100000 time units");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] crc_model(input logic [63:0] d);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int i = 0; i < 64; i++) begin
            fb = c[7] ^ d[i];
            c  = {c[6:0], 1'b0};
            if (fb) c = c ^ 8'h07;
        end
        return c;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end else begin
            $display("[TB] ok %s = %0h", name, act);
        end
    endtask

    task automatic clear_mon();
        mon_data.delete();
        mon_last.delete();
        mon_cyc.delete();
        ready_low = 0;
    endtask

    task automatic idle(input int n);
        wr_valid_i = 1'b0;
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // Called 1 time unit after a rising edge; returns 1 time unit after the accepting edge.
    task automatic drive_beat(input logic mode, input logic [3:0] d);
        int   guard;
        logic acc;
        guard      = 0;
        crc_mode_i = mode;
        wr_data_i  = d;
        wr_valid_i = 1'b1;
        do begin
            acc = wr_ready_o;
            @(posedge clk_i);
            #1;
            guard++;
        end while (!acc && guard < 50);
        if (!acc) begin
            tests++;
            fails++;
            $display("FAIL ready_timeout: wr_ready_o low for %0d cycles, required 1", guard);
        end
    endtask

    task automatic run_burst(input logic mode, input logic [63:0] d, input int gap_at,
                             input int gap_len, input int toggle_at);
        for (int i = 0; i < 16; i++) begin
            if (i == gap_at) idle(gap_len);
            drive_beat((i < toggle_at) ? mode : ~mode, d[4*i +: 4]);
        end
        wr_valid_i = 1'b0;
    endtask

    task automatic check_burst(input string tag, input int base, input logic mode,
                               input logic [63:0] d, input logic [7:0] exp_crc);
        int          n;
        logic [17:0] last_act;
        logic [17:0] last_exp;
        n = mode ? 18 : 16;
        if (mon_data.size() < base + n) begin
            tests++;
            fails++;
            $display("FAIL %s_len: got %0d output beats, required %0d", tag, mon_data.size() - base, n);
            return;
        end
        for (int i = 0; i < 16; i++)
            check($sformatf("%s_beat%0d", tag, i), mon_data[base+i], d[4*i +: 4]);
        if (mode) begin
            check($sformatf("%s_crc_lo", tag), mon_data[base+16], exp_crc[3:0]);
            check($sformatf("%s_crc_hi", tag), mon_data[base+17], exp_crc[7:4]);
        end
        last_act = '0;
        last_exp = '0;
        for (int i = 0; i < n; i++) last_act[i] = mon_last[base+i];
        last_exp[n-1] = 1'b1;
        check($sformatf("%s_last_pos", tag), last_act, last_exp);
    endtask

    typedef struct {
        logic        mode;
        logic [63:0] data;
        logic [7:0]  exp_crc;
    } vec_t;

    vec_t        vecs[8];
    logic [63:0] d_gap, d_a, d_b, d_c, d_rst, d_post;
    int          nlast;

    initial begin
        // Hand-derived CRCs: a single 1 on beat 15 DQ0 -> 07 shifted 3x = 38; on beat 15 DQ3 -> 07;
        // on beat 14 DQ0 -> 38 advanced 4 more zero bits = 89; both -> 89^38 = B1.
        vecs[0] = '{1'b0, 64'h0FEDCBA987654321, 8'h00};
        vecs[0].exp_crc = crc_model(vecs[0].data);
        vecs[1] = '{1'b1, 64'h0000000000000000, 8'h00};
        vecs[2] = '{1'b1, 64'h1000000000000000, 8'h38};
        vecs[3] = '{1'b1, 64'h8000000000000000, 8'h07};
        vecs[4] = '{1'b1, 64'h0100000000000000, 8'h89};
        vecs[5] = '{1'b1, 64'h1100000000000000, 8'hB1};
        vecs[6] = '{1'b1, {$urandom, $urandom}, 8'h00};
        vecs[6].exp_crc = crc_model(vecs[6].data);
        vecs[7] = '{1'b0, 64'h1000000000000000, 8'h38};

        // Reset values while reset is held.
        #2 rst_i = 1'b0;
        #2;
        check("rst_wr_ready", wr_ready_o, 1'b1);
        check("rst_dq_valid", dq_valid_o, 1'b0);
        check("rst_dq_data", dq_data_o, 4'h0);
        check("rst_dq_last", dq_last_o, 1'b0);
        check("rst_crc_o", crc_o, 8'h00);
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;

        for (int v = 0; v < 8; v++) begin
            int n;
            n = vecs[v].mode ? 18 : 16;
            clear_mon();
            run_burst(vecs[v].mode, vecs[v].data, -1, 0, 16);
            idle(4);
            check_burst($sformatf("vec%0d", v), 0, vecs[v].mode, vecs[v].data, vecs[v].exp_crc);
            check($sformatf("vec%0d_crc_o", v), crc_o, vecs[v].exp_crc);
            check($sformatf("vec%0d_ready_low", v), ready_low, vecs[v].mode ? 2 : 0);
            if (mon_cyc.size() >= n)
                check($sformatf("vec%0d_contiguous", v), mon_cyc[n-1] - mon_cyc[0], n - 1);
        end

        // Three idle cycles after beat 5: output gap of 3 cycles, CRC unaffected.
        d_gap = {$urandom, $urandom};
        clear_mon();
        run_burst(1'b1, d_gap, 6, 3, 16);
        idle(4);
        check_burst("gap", 0, 1'b1, d_gap, crc_model(d_gap));
        check("gap_crc_o", crc_o, crc_model(d_gap));
        if (mon_cyc.size() >= 7)
            check("gap_spacing", mon_cyc[6] - mon_cyc[5], 4);

        // Mode dropped mid-burst, then two back-to-back BL16 bursts.
        d_a = {$urandom, $urandom};
        d_b = {$urandom, $urandom};
        d_c = 64'h0FEDCBA987654321;
        clear_mon();
        run_burst(1'b1, d_a, -1, 0, 8);
        run_burst(1'b0, d_b, -1, 0, 16);
        run_burst(1'b0, d_c, -1, 0, 16);
        idle(4);
        check_burst("tog_a", 0, 1'b1, d_a, crc_model(d_a));
        check_burst("tog_b", 18, 1'b0, d_b, 8'h00);
        check_burst("tog_c", 34, 1'b0, d_c, 8'h00);
        check("tog_crc_o", crc_o, crc_model(d_c));
        check("tog_ready_low", ready_low, 2);
        check("tog_beats", mon_data.size(), 50);
        if (mon_cyc.size() >= 50)
            check("tog_contiguous", mon_cyc[49] - mon_cyc[0], 49);

        // Asynchronous reset after beat 9 of a CRC burst.
        d_rst  = {$urandom, $urandom};
        d_post = {$urandom, $urandom};
        clear_mon();
        for (int i = 0; i < 10; i++) drive_beat(1'b1, d_rst[4*i +: 4]);
        wr_valid_i = 1'b0;
        #2 rst_i = 1'b0;
        #1;
        check("mid_rst_wr_ready", wr_ready_o, 1'b1);
        check("mid_rst_dq_valid", dq_valid_o, 1'b0);
        check("mid_rst_dq_data", dq_data_o, 4'h0);
        check("mid_rst_dq_last", dq_last_o, 1'b0);
        check("mid_rst_crc_o", crc_o, 8'h00);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        nlast = 0;
        foreach (mon_last[k]) if (mon_last[k]) nlast++;
        check("mid_rst_no_last", nlast, 0);
        clear_mon();
        run_burst(1'b1, d_post, -1, 0, 16);
        idle(4);
        check_burst("post_rst", 0, 1'b1, d_post, crc_model(d_post));
        check("post_rst_crc_o", crc_o, crc_model(d_post));
        check("post_rst_ready_low", ready_low, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
